edge_detector_bank: RTL
=======================

// Module: edge_detector_bank
//
// PURPOSE
//   Parametrised multi-channel successor to the single-bit edge detector.
//   Each of CHANNELS asynchronous inputs is synchronised, optionally
//   debounced, and watched for rising, falling or both edges according to a
//   per-channel mode. Every detected edge gives a one-cycle pulse and sets a
//   sticky pending flag; clearing is write-1-to-clear. An OR of pending flags
//   drives an interrupt line. Sits between buttons/external strobes and
//   control FSMs.
//
// PARAMETERS
//   CHANNELS         4   number of independent input channels (>=1)
//   SYNC_STAGES      2   synchroniser flops per channel (>=2)
//   DEBOUNCE_CYCLES  16  consecutive stable cycles to accept a new level
//                        (>=1; used only with DEBOUNCE_EN)
//
// PORTS
//   clk      in   1           single clock, all logic on posedge
//   rst      in   1           synchronous reset, active-low
//   in       in   CHANNELS    raw asynchronous inputs
//   mode     in   2*CHANNELS  per ch [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//   clr      in   CHANNELS    W1C: clr[i]=1 clears pending[i] this cycle
//   level    out  CHANNELS    filtered (synced/debounced) level
//   pulse    out  CHANNELS    1-cycle strobe per accepted edge
//   pending  out  CHANNELS    sticky event flags
//   irq      out  1           |pending
//
// BEHAVIOUR
//   - Reset (rst==0 at posedge): sync chain, level, prev-level, pending, arm
//     counter all 0. Outputs level/pulse/pending/irq = 0 during and after reset.
//   - Sync: in[i] through SYNC_STAGES flops; last stage = s[i].
//   - Level: without debounce level[i] = s[i]. prev[i] <= level[i] each cycle.
//   - Edge: rise = level & ~prev; fall = ~level & prev; pulse[i] selected by
//     mode[i]; mode 00 -> pulse 0. Pulse is decoded from registers; no
//     combinational path from in.
//   - Latency (no debounce): in[i] changes before edge k -> pulse[i] high for
//     exactly the cycle after edge k+SYNC_STAGES-1.
//   - Arm: after reset release, pulses are suppressed for SYNC_STAGES+1 cycles
//     (pipeline fill). An input held high through reset gives no rise pulse;
//     level still follows.
//   - Pending: set when pulse[i]=1, cleared when clr[i]=1. Set and clear in
//     the same cycle -> stays 1 (events are never lost). Clearing an already
//     clear flag is a no-op.
//   - irq registered-free: irq = |pending, same cycle as pending.
//   - mode change takes effect on the next cycle's decode; pending and level
//     are unaffected; no pulse is generated by the mode change itself.
//   - Reset mid-operation: all state cleared next edge, arm restarts;
//     in-flight edges are dropped.
//
// CONFIGURATION
//   DEBOUNCE_EN defined: per-channel counter, width $clog2(DEBOUNCE_CYCLES+1).
//     When s[i]!=level[i], counter increments; when s[i]==level[i], it resets
//     to 0. When counter reaches DEBOUNCE_CYCLES, level[i]<=s[i] and the
//     counter resets. Glitches shorter than DEBOUNCE_CYCLES cycles give no
//     level change and no pulse. Adds DEBOUNCE_CYCLES cycles of latency.
//     Counters reset to 0.
//   DEBOUNCE_EN undefined: no counters; level = s; DEBOUNCE_CYCLES ignored.
//
// TESTING
//   1 CH=4, mode=all 01: in[0] 0->1 after arm -> pulse[0] one cycle
//     SYNC_STAGES edges later, pending[0]=1, irq=1; no other channel moves.
//   2 mode[1]=11: in[1] 0->1, hold 10, 1->0 -> two pulses;
//     mode[2]=10: same stimulus -> only the falling pulse.
//   3 pending[0]=1; clr[0] pulsed in the same cycle as a new pulse[0]
//     -> pending[0] stays 1; next clr[0] alone -> 0, irq=0.
//   4 in=4'hF held through reset, release -> level=F after sync, no pulse,
//     pending=0; rst low mid-burst -> all outputs 0 next edge.
//   5 DEBOUNCE_EN, DEBOUNCE_CYCLES=16: 5-cycle glitch -> no level change or
//     pulse; 20-cycle high -> one pulse after SYNC_STAGES+16 cycles.
//   6 mode=00 on ch3, toggle in[3] -> level follows, pulse[3]=0, pending[3]=0.

Source files
------------

// File: rtl/edge_detector_bank.sv
// edge_detector_bank: multi-channel synchronise / filter / edge-detect bank.
// Each channel runs its raw input through a synchroniser, optionally a
// debounce filter, and decodes rising/falling edges against a per-channel
// mode. Detected edges strobe pulse for one cycle and set a sticky pending
// flag (write-1-to-clear); irq is the OR of all pending flags.
// Optional feature macro: DEBOUNCE_EN (per-channel debounce counters).
module edge_detector_bank #(
   parameter int CHANNELS        = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CHANNELS-1:0]   in,
   input  logic [2*CHANNELS-1:0] mode,
   input  logic [CHANNELS-1:0]   clr,
   output logic [CHANNELS-1:0]   level,
   output logic [CHANNELS-1:0]   pulse,
   output logic [CHANNELS-1:0]   pending,
   output logic                  irq
);

   // Pulses stay suppressed until the synchroniser and prev-level flops
   // hold post-reset data, so a level present through reset is not an edge.
   localparam int ARM_CYCLES = SYNC_STAGES + 1;
   localparam int ARM_W      = $clog2(ARM_CYCLES + 1);

   // Elaboration-time guard against unusable parameter values.
   if (CHANNELS < 1 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
      $error("edge_detector_bank: illegal parameter value");
   end

   logic [CHANNELS-1:0]   sync_q [SYNC_STAGES];
   logic [CHANNELS-1:0]   sync_s;
   logic [CHANNELS-1:0]   level_s;
   logic [CHANNELS-1:0]   prev_q;
   logic [2*CHANNELS-1:0] mode_q;
   logic [ARM_W-1:0]      arm_q;
   logic [ARM_W-1:0]      arm_d;
   logic                  armed_s;
   logic [CHANNELS-1:0]   pulse_s;
   logic [CHANNELS-1:0]   pending_q;
   logic [CHANNELS-1:0]   pending_d;

   // Synchroniser chain: stage 0 samples the raw inputs, last stage is s.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= {CHANNELS{1'b0}};
         end
      end else begin
         sync_q[0] <= in;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
      end
   end

   assign sync_s = sync_q[SYNC_STAGES-1];

`ifdef DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [CNT_W-1:0]    cnt_q [CHANNELS];
   logic [CNT_W-1:0]    cnt_d [CHANNELS];
   logic [CHANNELS-1:0] level_q;
   logic [CHANNELS-1:0] level_d;

   // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive
   // cycles of disagreement; any agreement restarts the count.
   always_comb begin
      level_d = level_q;
      for (int i = 0; i < CHANNELS; i++) begin
         cnt_d[i] = cnt_q[i];
         if (sync_s[i] != level_q[i]) begin
            if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               level_d[i] = sync_s[i];
               cnt_d[i]   = {CNT_W{1'b0}};
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end else begin
            cnt_d[i] = {CNT_W{1'b0}};
         end
      end
   end

   // Debounce state registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         level_q <= {CHANNELS{1'b0}};
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i] <= {CNT_W{1'b0}};
         end
      end else begin
         level_q <= level_d;
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign level_s = level_q;
`else
   assign level_s = sync_s;
`endif

   // Previous level and registered mode feed the edge decode.
   always_ff @(posedge clk) begin
      if (!rst) begin
         prev_q <= {CHANNELS{1'b0}};
         mode_q <= {(2*CHANNELS){1'b0}};
      end else begin
         prev_q <= level_s;
         mode_q <= mode;
      end
   end

   // Arm counter saturates once the pipeline has refilled after reset.
   always_comb begin
      if (armed_s) begin
         arm_d = arm_q;
      end else begin
         arm_d = arm_q + ARM_W'(1);
      end
   end

   assign armed_s = (arm_q == ARM_W'(ARM_CYCLES));

   // Arm counter register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         arm_q <= {ARM_W{1'b0}};
      end else begin
         arm_q <= arm_d;
      end
   end

   // Edge decode per channel, selected by the registered mode.
   always_comb begin
      pulse_s = {CHANNELS{1'b0}};
      for (int i = 0; i < CHANNELS; i++) begin
         case (mode_q[2*i +: 2])
            2'b00:   pulse_s[i] = 1'b0;
            2'b01:   pulse_s[i] = level_s[i] & ~prev_q[i];
            2'b10:   pulse_s[i] = ~level_s[i] & prev_q[i];
            2'b11:   pulse_s[i] = level_s[i] ^ prev_q[i];
            default: pulse_s[i] = 1'b0;
         endcase
         if (!armed_s) begin
            pulse_s[i] = 1'b0;
         end else begin
            pulse_s[i] = pulse_s[i];
         end
      end
   end

   // A new event wins over a simultaneous clear so no event is lost.
   always_comb begin
      pending_d = (pending_q & ~clr) | pulse_s;
   end

   // Sticky pending flags.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pending_q <= {CHANNELS{1'b0}};
      end else begin
         pending_q <= pending_d;
      end
   end

   assign level   = level_s;
   assign pulse   = pulse_s;
   assign pending = pending_q;
   assign irq     = |pending_q;

endmodule
